// File: rtl/rom_port_arbiter.sv
// Three byte-wide ROM requesters share one 16-bit SDRAM read port.
// Each requester keeps a one-word cache; misses go through a round-robin toggle handshake.

module rom_port_cache (
   input  logic        clk_sys,
   input  logic        res_n_i,
   input  logic        dl_active,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic        fill_en,
   input  logic [14:0] fill_tag,
   input  logic [15:0] fill_data,
   output logic        hit,
   output logic        rdy,
   output logic [7:0]  dout
);
   logic        valid;
   logic [14:0] tag;
   logic [15:0] data;

   assign hit = req & valid & (tag == addr[15:1]) & ~dl_active;

   always_ff @(posedge clk_sys or negedge res_n_i) begin
      if (!res_n_i) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
         rdy   <= 1'b0;
         dout  <= '0;
      end else begin
         if (dl_active) begin
            valid <= 1'b0;
         end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
         end
         rdy  <= hit;
         dout <= addr[0] ? data[15:8] : data[7:0];
      end
   end
endmodule

module rom_port_arbiter #(
   parameter logic [22:0] BASE0   = 23'h000000,
   parameter logic [22:0] BASE1   = 23'h006000,
   parameter logic [22:0] BASE2   = 23'h008000,
   parameter int          TIMEOUT = 255
) (
   input  logic        clk_sys,
   input  logic        res_n_i,
   input  logic        dl_active,
   input  logic [15:0] m_addr,
   input  logic        m_req,
   output logic [7:0]  m_dout,
   output logic        m_rdy,
   input  logic [15:0] s_addr,
   input  logic        s_req,
   output logic [7:0]  s_dout,
   output logic        s_rdy,
   input  logic [15:0] p_addr,
   input  logic        p_req,
   output logic [7:0]  p_dout,
   output logic        p_rdy,
   output logic        sd_req,
   input  logic        sd_ack,
   output logic [22:0] sd_addr,
   input  logic [15:0] sd_q,
   output logic        err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL} state_t;
   state_t state, state_nxt;

   logic [2:0][15:0] addr_a;
   logic [2:0][7:0]  dout_a;
   logic [2:0]       req_a, hit_a, rdy_a, miss_a, fill_sel;
   logic [1:0]       ptr, gnt, gnt_nxt;
   logic [2:0][1:0]  ord;
   logic [14:0]      word;
   logic [CW-1:0]    cnt;
   logic             sync, issue, fill_en, tmo;

   assign addr_a = {p_addr, s_addr, m_addr};
   assign req_a  = {p_req, s_req, m_req};
   assign miss_a = req_a & ~hit_a & {3{~dl_active}};
   assign sync   = (sd_ack == sd_req);
   assign fill_sel = fill_en ? (3'b001 << gnt) : 3'b000;

   assign {p_rdy, s_rdy, m_rdy}    = rdy_a;
   assign {p_dout, s_dout, m_dout} = dout_a;

   for (genvar i = 0; i < 3; i++) begin : g_lane
      rom_port_cache u_cache (
         .clk_sys   (clk_sys),
         .res_n_i   (res_n_i),
         .dl_active (dl_active),
         .req       (req_a[i]),
         .addr      (addr_a[i]),
         .fill_en   (fill_sel[i]),
         .fill_tag  (word),
         .fill_data (sd_q),
         .hit       (hit_a[i]),
         .rdy       (rdy_a[i]),
         .dout      (dout_a[i])
      );
   end

   function automatic logic [22:0] base_of(input logic [1:0] i);
      case (i)
         2'd1:    return BASE1;
         2'd2:    return BASE2;
         default: return BASE0;
      endcase
   endfunction

   // Search order starts just after the last grant; scanning backwards lets the first hit win.
   always_comb begin
      case (ptr)
         2'd0:    ord = {2'd0, 2'd2, 2'd1};
         2'd1:    ord = {2'd1, 2'd0, 2'd2};
         default: ord = {2'd2, 2'd1, 2'd0};
      endcase
      gnt_nxt = ptr;
      for (int k = 2; k >= 0; k--)
         if (miss_a[ord[k]]) gnt_nxt = ord[k];
   end

   always_ff @(posedge clk_sys or negedge res_n_i) begin
      if (!res_n_i) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (|miss_a && sync) state_nxt = S_WAIT;
         S_WAIT:  if (sync) state_nxt = S_FILL;
                  else if (cnt == CNT_LAST) state_nxt = S_IDLE;
         S_FILL:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Issue only when in sync, so a late ack after a timeout is absorbed first.
   always_comb begin
      issue   = 1'b0;
      fill_en = 1'b0;
      tmo     = 1'b0;
      case (state)
         S_IDLE:  issue   = |miss_a & sync;
         S_WAIT:  tmo     = ~sync & (cnt == CNT_LAST);
         S_FILL:  fill_en = ~dl_active;
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or negedge res_n_i) begin
      if (!res_n_i) begin
         sd_req  <= 1'b0;
         sd_addr <= '0;
         gnt     <= 2'd0;
         ptr     <= 2'd2;
         word    <= '0;
         cnt     <= '0;
         err     <= 1'b0;
      end else begin
         if (issue) begin
            sd_req  <= ~sd_req;
            sd_addr <= base_of(gnt_nxt) + {7'b0, addr_a[gnt_nxt][15:1]};
            gnt     <= gnt_nxt;
            ptr     <= gnt_nxt;
            word    <= addr_a[gnt_nxt][15:1];
            cnt     <= '0;
         end else if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
         end
         if (tmo) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench: expected SDRAM addresses are queued at stimulus time and checked on each sd_req toggle.

module tb_rom_port_arbiter;
   logic        clk_sys = 1'b0;
   logic        res_n_i;
   logic        dl_active;
   logic [15:0] m_addr, s_addr, p_addr;
   logic        m_req, s_req, p_req;
   logic [7:0]  m_dout, s_dout, p_dout;
   logic        m_rdy, s_rdy, p_rdy;
   logic        sd_req, sd_ack, err;
   logic [22:0] sd_addr;
   logic [15:0] sd_q;

   int checks = 0;
   int errors = 0;
   logic [22:0] exp_q[$];
   logic prev_req = 1'b0;

   rom_port_arbiter dut (
      .clk_sys(clk_sys), .res_n_i(res_n_i), .dl_active(dl_active),
      .m_addr(m_addr), .m_req(m_req), .m_dout(m_dout), .m_rdy(m_rdy),
      .s_addr(s_addr), .s_req(s_req), .s_dout(s_dout), .s_rdy(s_rdy),
      .p_addr(p_addr), .p_req(p_req), .p_dout(p_dout), .p_rdy(p_rdy),
      .sd_req(sd_req), .sd_ack(sd_ack), .sd_addr(sd_addr), .sd_q(sd_q),
      .err(err)
   );

   always #5 clk_sys = ~clk_sys;

   // Every sd_req toggle must match the next queued address.
   always @(negedge clk_sys) begin : mon
      logic [22:0] e;
      if (res_n_i === 1'b1 && sd_req !== prev_req) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sd_issue: unexpected toggle sd_addr=%h, required no toggle", sd_addr);
         end else begin
            e = exp_q.pop_front();
            if (sd_addr !== e) begin
               errors++;
               $display("FAIL sd_addr: got %h required %h", sd_addr, e);
            end
         end
      end
      prev_req = sd_req;
   end

   task automatic wait_issue(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk_sys);
         if (sd_req !== sd_ack) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_issue: no outstanding request within 60 cycles, required one", nm);
      end
   endtask

   task automatic serve(input int dly, input logic [15:0] q, input string nm);
      wait_issue(nm);
      repeat (dly) @(posedge clk_sys);
      #1 sd_q = q;
      sd_ack = sd_req;
   endtask

   task automatic test_reset();
      res_n_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_addr = 16'($urandom); s_addr = 16'($urandom); p_addr = 16'($urandom);
         m_req = 1'($urandom); s_req = 1'($urandom); p_req = 1'($urandom);
         dl_active = 1'($urandom); sd_ack = 1'($urandom); sd_q = 16'($urandom);
         @(posedge clk_sys); #1;
      end
      @(negedge clk_sys);
      checks++; if ({m_rdy, s_rdy, p_rdy} !== 3'b000) begin errors++; $display("FAIL rst_rdy: got %b required 000", {m_rdy, s_rdy, p_rdy}); end
      checks++; if ({m_dout, s_dout, p_dout} !== 24'h0) begin errors++; $display("FAIL rst_dout: got %h required 000000", {m_dout, s_dout, p_dout}); end
      checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL rst_sd_req: got %b required 0", sd_req); end
      checks++; if (sd_addr !== 23'h0) begin errors++; $display("FAIL rst_sd_addr: got %h required 0", sd_addr); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", err); end
      m_req = 1'b0; s_req = 1'b0; p_req = 1'b0; dl_active = 1'b0; sd_ack = 1'b0;
      @(posedge clk_sys); #1 res_n_i = 1'b1;
      repeat (10) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL idle_sd_req: got %b required 0", sd_req); end
   endtask

   task automatic test_miss_hit();
      @(posedge clk_sys); #1;
      m_addr = 16'h0123; m_req = 1'b1; exp_q.push_back(23'h000091);
      serve(5, 16'hBEEF, "miss");
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if (m_rdy !== 1'b0) begin errors++; $display("FAIL fill_rdy_early: got %b required 0", m_rdy); end
      @(posedge clk_sys); @(negedge clk_sys);
      checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy: got %b required 1", m_rdy); end
      checks++; if (m_dout !== 8'hBE) begin errors++; $display("FAIL fill_dout: got %h required be", m_dout); end
      @(posedge clk_sys); #1 m_addr = 16'h0122;
      @(posedge clk_sys); @(negedge clk_sys);
      checks++; if (m_rdy !== 1'b1 || m_dout !== 8'hEF) begin errors++; $display("FAIL hit_low: got rdy=%b dout=%h required 1 ef", m_rdy, m_dout); end
      @(posedge clk_sys); #1 m_req = 1'b0;
      @(posedge clk_sys); @(negedge clk_sys);
      checks++; if (m_rdy !== 1'b0) begin errors++; $display("FAIL rdy_drop: got %b required 0", m_rdy); end
   endtask

   task automatic test_offsets();
      @(posedge clk_sys); #1;
      s_addr = 16'h0004; s_req = 1'b1; exp_q.push_back(23'h006002);
      serve(2, 16'h1234, "sound");
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if (s_rdy !== 1'b1 || s_dout !== 8'h34) begin errors++; $display("FAIL sound: got rdy=%b dout=%h required 1 34", s_rdy, s_dout); end
      @(posedge clk_sys); #1 s_req = 1'b0;
      p_addr = 16'hFFFF; p_req = 1'b1; exp_q.push_back(23'h00FFFF);
      serve(1, 16'hA55A, "sprite");
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if (p_rdy !== 1'b1 || p_dout !== 8'hA5) begin errors++; $display("FAIL sprite: got rdy=%b dout=%h required 1 a5", p_rdy, p_dout); end
      @(posedge clk_sys); #1 p_req = 1'b0;
   endtask

   task automatic test_fairness();
      @(posedge clk_sys); #1 res_n_i = 1'b0; sd_ack = 1'b0;
      @(posedge clk_sys); #1 res_n_i = 1'b1;
      m_addr = 16'h0010; s_addr = 16'h0020; p_addr = 16'h0030;
      m_req = 1'b1; s_req = 1'b1; p_req = 1'b1;
      exp_q.push_back(23'h000008); exp_q.push_back(23'h006010); exp_q.push_back(23'h008018);
      serve(3, 16'h0A11, "rr0");
      serve(3, 16'h0B22, "rr1");
      serve(3, 16'h0C33, "rr2");
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if ({m_rdy, s_rdy, p_rdy} !== 3'b111) begin errors++; $display("FAIL rr_rdy: got %b required 111", {m_rdy, s_rdy, p_rdy}); end
      checks++; if ({m_dout, s_dout, p_dout} !== 24'h112233) begin errors++; $display("FAIL rr_dout: got %h required 112233", {m_dout, s_dout, p_dout}); end
      @(posedge clk_sys); #1;
      m_addr = 16'h0040; s_addr = 16'h0050;
      exp_q.push_back(23'h000020); exp_q.push_back(23'h006028);
      serve(2, 16'h0D44, "rr3");
      @(negedge clk_sys);
      checks++; if (p_rdy !== 1'b1) begin errors++; $display("FAIL hit_in_wait: got %b required 1", p_rdy); end
      serve(2, 16'h0E55, "rr4");
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if ({m_dout, s_dout} !== 16'h4455 || {m_rdy, s_rdy} !== 2'b11) begin errors++; $display("FAIL rr2_dout: got rdy=%b dout=%h required 11 4455", {m_rdy, s_rdy}, {m_dout, s_dout}); end
      @(posedge clk_sys); #1 m_req = 1'b0; s_req = 1'b0; p_req = 1'b0;
   endtask

   task automatic test_download();
      @(posedge clk_sys); #1;
      m_addr = 16'h0200; m_req = 1'b1; exp_q.push_back(23'h000100);
      wait_issue("dl");
      @(posedge clk_sys); #1 dl_active = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1 sd_q = 16'h1234; sd_ack = sd_req;
      repeat (5) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if ({m_rdy, s_rdy, p_rdy} !== 3'b000) begin errors++; $display("FAIL dl_rdy: got %b required 000", {m_rdy, s_rdy, p_rdy}); end
      @(posedge clk_sys); #1 exp_q.push_back(23'h000100); dl_active = 1'b0;
      @(posedge clk_sys); @(negedge clk_sys);
      checks++; if (m_rdy !== 1'b0) begin errors++; $display("FAIL dl_post_rdy: got %b required 0", m_rdy); end
      serve(1, 16'h5AC3, "dl_re");
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if (m_rdy !== 1'b1 || m_dout !== 8'hC3) begin errors++; $display("FAIL dl_refill: got rdy=%b dout=%h required 1 c3", m_rdy, m_dout); end
      @(posedge clk_sys); #1 m_req = 1'b0;
   endtask

   task automatic test_timeout();
      int n = 0;
      @(posedge clk_sys); #1;
      m_addr = 16'h0300; m_req = 1'b1; exp_q.push_back(23'h000180);
      wait_issue("tmo");
      while (n < 400 && err !== 1'b1) begin
         @(posedge clk_sys); n++;
         @(negedge clk_sys);
      end
      checks++; if (err !== 1'b1 || n != 255) begin errors++; $display("FAIL tmo_err: got err=%b after %0d cycles required 1 after 255", err, n); end
      repeat (20) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if (m_rdy !== 1'b0) begin errors++; $display("FAIL tmo_rdy: got %b required 0", m_rdy); end
      @(posedge clk_sys); #1 exp_q.push_back(23'h000180); sd_ack = sd_req;
      serve(2, 16'h7E81, "tmo_re");
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      checks++; if (m_rdy !== 1'b1 || m_dout !== 8'h81) begin errors++; $display("FAIL tmo_refill: got rdy=%b dout=%h required 1 81", m_rdy, m_dout); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", err); end
      @(posedge clk_sys); #1 m_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_miss_hit();
      test_offsets();
      test_fairness();
      test_download();
      test_timeout();
      repeat (5) @(posedge clk_sys);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected requests never issued, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one 16-bit SDRAM word-read port between three byte-wide ROM requesters: main CPU (0), sound CPU (1) and sprite engine (2).
- Each requester has a one-word cache; misses are serialized by a round-robin arbiter using the SDRAM controller's toggle req/ack handshake.
- Sits between SEGASYSTEM1 ROM fetch ports and the sdram block.
- Idles and invalidates all caches while a ROM download is in progress.

Parameters:
- BASE0, 23'h000000, word offset added for requester 0.
- BASE1, 23'h006000, word offset added for requester 1.
- BASE2, 23'h008000, word offset added for requester 2.
- TIMEOUT, 255, max clk_sys cycles waiting for ack before abort.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- res_n_i  in  1  asynchronous active-low reset.
- dl_active  in  1  ROM download in progress (ioctl_downl).
- m_addr  in  16  requester 0 byte address.
- m_req  in  1  requester 0 read request, level.
- m_dout  out  8  requester 0 byte data.
- m_rdy  out  1  requester 0 data valid.
- s_addr, s_req, s_dout, s_rdy: same for requester 1.
- p_addr, p_req, p_dout, p_rdy: same for requester 2.
- sd_req  out  1  SDRAM request toggle.
- sd_ack  in  1  SDRAM ack toggle; equals sd_req when done.
- sd_addr  out  23  SDRAM word address.
- sd_q  in  16  SDRAM read word; valid when sd_ack == sd_req.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (res_n_i=0, asynchronous): all cache valid bits 0; tags and data 0; all *_rdy 0; all *_dout 0; sd_req 0; sd_addr 0; err 0; FSM IDLE; RR pointer 2, so requester 0 has top priority first.
- Hit(i) = req(i) & valid(i) & tag(i)==addr(i)[15:1] & ~dl_active.
- rdy(i) is registered every cycle as Hit(i). dout(i) is registered as addr[0] ? data[15:8] : data[7:0].
- Hit latency is 1 cycle. rdy stays high while req is held on a hitting address. rdy drops the cycle after req drops or the address leaves the cached word.
- Miss(i) = req(i) & ~Hit(i) & ~dl_active, evaluated in IDLE.
- FSM states:
  - IDLE: if any Miss, grant the first missing requester after the RR pointer (order ptr+1, ptr+2, ptr, mod 3). Latch the grant index and word address addr[15:1]. Drive sd_addr = BASEi + {7'b0, addr[15:1]} (23-bit add, overflow wraps). Toggle sd_req. Update pointer = grant. Go to WAIT. Clear the timeout counter.
  - WAIT: the counter increments each cycle.
    - If sd_ack == sd_req: go to FILL.
    - Else if counter reaches TIMEOUT: set err; cache unchanged; go to IDLE.
    - Late acks after a timeout must not corrupt state. Resynchronize by issuing the next request only once sd_ack == sd_req.
  - FILL (1 cycle): write sd_q into data(grant), set tag(grant) = latched word address and valid(grant) = 1, unless dl_active. Go to IDLE.
  - The requester's rdy rises the cycle after FILL if its address still matches. If the address changed, it misses again and re-arbitrates.
- Only one SDRAM transaction is outstanding. No new issue while sd_req != sd_ack.
- Requesters whose cache hits never enter arbitration and are served during another requester's WAIT.
- dl_active=1:
  - All valid bits are cleared every cycle.
  - All rdy are 0; no new grants.
  - An in-flight WAIT completes; FILL discards the data.
  - After dl_active falls, the first accesses miss.
- sd_req and sd_addr hold their values between transactions.
- Simultaneous miss from all three with pointer at 2 gives grant order 0, 1, 2.
- Reset mid-transaction returns all state to reset values. A pending ack from the controller is absorbed by the sd_ack == sd_req resync rule.

Test Plan:
- Reset: hold res_n_i=0 with random inputs -> all rdy/dout/sd_req/sd_addr/err are 0; release -> no sd_req toggle while all req are 0.
- Miss, then hit:
  - m_req=1, m_addr=16'h0123 -> sd_req toggles to 1 and sd_addr=23'h000091.
  - sd_ack toggles after 5 cycles with sd_q=16'hBEEF -> the cycle after FILL, m_rdy=1 and m_dout=8'hBE.
  - Then m_addr=16'h0122 -> m_rdy=1, m_dout=8'hEF one cycle later, no sd_req toggle.
- Sound offset: s_addr=16'h0004 miss -> sd_addr=23'h006002. Sprite p_addr=16'hFFFF -> sd_addr=23'h00FFFF.
- Fairness: m_req, s_req and p_req all miss in the same cycle after reset -> grants 0, 1, 2 in sequence. Then, with 0 and 1 both missing again -> grant 0 (pointer at 2).
- Download: dl_active=1 during WAIT, ack arrives -> no rdy, valid stays 0. After dl_active=0, the same address re-issues sd_req.
- Timeout: never toggle sd_ack -> after 255 WAIT cycles err=1 and FSM is IDLE. No new sd_req toggle until sd_ack matches, then err remains 1 until reset.
